pwm_sample_averager: RTL and testbench
======================================

# pwm_sample_averager

Sliding-window averager that sits directly upstream of the PWM data mux in the PWM measurement path. It accepts 8-bit raw PWM ADC samples with a valid strobe and keeps a circular buffer of the last 2^LOG2_N samples with a running sum. It produces the 12-bit averaged value (4 fractional bits, i.e. raw×16 scale) that the mux routes to the display when AVERAGED is selected.

## Interface
- LOG2_N, default 4, log2 of window length N; legal range 1..8 (N = 2..256).
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- raw_valid  input  1  one-cycle strobe; raw_data is sampled when high.
- raw_data  input  8  raw PWM ADC sample.
- flush  input  1  synchronous clear of window, sum and fill count.
- pwm_averaged  output  12  averaged result, raw×16 scale.
- avg_valid  output  1  one-cycle pulse when pwm_averaged updates.
- window_full  output  1  high while N samples are held.

## Operation
- Storage: buffer[0..N-1] of 8 bits, write pointer wr_ptr (LOG2_N bits), running sum (8+LOG2_N bits), fill count (LOG2_N+1 bits, saturates at N).
- Fill states: EMPTY (count=0), FILLING (0<count<N), FULL (count=N).
  - EMPTY→FILLING on accepted sample.
  - FILLING→FULL when the accepted sample makes count=N.
  - Any state→EMPTY on flush.
- Accepted sample (raw_valid=1, flush=0):
  - old = buffer[wr_ptr]. This reads as 0 for never-written slots, because flush and reset zero the buffer.
  - sum <= sum + raw_data − old.
  - buffer[wr_ptr] <= raw_data.
  - wr_ptr <= wr_ptr+1, wrapping N−1→0.
  - count <= min(count+1, N).
- Output stage, one cycle after acceptance:
  - pwm_averaged <= (sum×16) >> LOG2_N, truncated to 12 bits.
  - Maximum is 255×16 = 4080, so no overflow.
  - The divide is a shift only; fractional bits beyond 4 are truncated, no rounding.
- Sum never goes negative, since old is always a previously added value. No saturation logic is required.
- flush=1: buffer, sum, wr_ptr and count clear on that edge. A raw_valid in the same cycle is dropped (flush wins). pwm_averaged holds its last value; avg_valid is not pulsed.
- Back-to-back raw_valid on every cycle is supported with no stall; there is no ready signal.
- window_full = (count == N), registered along with count.

## Timing
- Reset (asynchronous assert) clears everything to zero:
  - pwm_averaged = 0, avg_valid = 0, window_full = 0.
  - sum, count, wr_ptr and all buffer entries = 0.
- Latency: raw_valid high at edge k → sum updated at edge k → pwm_averaged and avg_valid asserted at edge k+1, for 1 cycle.
- Throughput: 1 sample/cycle; avg_valid pulses once per accepted sample (subject to Configuration).
- window_full rises at the edge that accepts the Nth sample after reset/flush, one cycle before the corresponding avg_valid.
- Reset mid-operation discards any in-flight output pulse; no avg_valid follows reset deassertion.
- Flush at edge k cancels an avg_valid due at edge k+1 only if the sample for it was accepted at edge k. Because flush drops that same-cycle sample, an avg_valid scheduled from edge k−1 still fires.

## Configuration
- PWM_AVG_WARMUP_EN
  - Defined: avg_valid is suppressed while the window is not full. The first avg_valid after reset/flush is the one following the Nth accepted sample. pwm_averaged still updates internally, but downstream consumers only sample it on avg_valid.
  - Undefined: avg_valid pulses for every accepted sample from the first. During fill, the result is averaged against zero-filled slots, so it ramps up toward the true mean.

## Test plan
- LOG2_N=4, reset, then 16 samples of 0x80, one per cycle → window_full rises at the 16th acceptance. pwm_averaged = 0x800 one cycle later. Without PWM_AVG_WARMUP_EN the first output is 0x080 (128×16/16 after one sample).
- Full window of 0xFF, continuous valid → pwm_averaged = 4080 (0xFF0), steady; no overflow on continued input.
- Full window of 0x10, then 16 samples of 0x20 → pwm_averaged steps by +1 (0x100→0x200 in 16 increments of 0x010). This exercises wr_ptr wrap and old-sample subtraction.
- Samples 1,2 with LOG2_N=1 → average (1+2)×16/2 = 24 (0x018), checking the shift arithmetic; then alternating 0/1 gives 8 (0x008).
- flush and raw_valid asserted together mid-window → sample dropped, window_full=0, count restarts. The next single sample of 0x40 yields 0x040 (warmup off) or no avg_valid (warmup on).
- Assert reset during a burst, release, send 1 sample → no stray avg_valid after release; all outputs read 0 until the new sample's output cycle.

Source files
------------

// File: rtl/pwm_sample_averager.sv
// Sliding-window average of 8-bit PWM ADC samples over 2^LOG2_N entries, output at raw x16 scale.
// Optional macro PWM_AVG_WARMUP_EN holds off avg_valid until the window has filled once.
module pwm_sample_averager #(
  parameter int LOG2_N = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        raw_valid,
  input  logic [7:0]  raw_data,
  input  logic        flush,
  output logic [11:0] pwm_averaged,
  output logic        avg_valid,
  output logic        window_full
);

  localparam int N     = 1 << LOG2_N;
  localparam int SUM_W = 8 + LOG2_N;
  localparam logic [LOG2_N:0]   CNT_FULL = {1'b1, {LOG2_N{1'b0}}};
  localparam logic [LOG2_N:0]   CNT_ONE  = (LOG2_N + 1)'(1);
  localparam logic [LOG2_N-1:0] PTR_ONE  = LOG2_N'(1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} fill_state_t;

  fill_state_t       r_state, w_stateNext;
  logic [7:0]        r_buf [N];
  logic [LOG2_N-1:0] r_wrPtr;
  logic [SUM_W-1:0]  r_sum;
  logic [LOG2_N:0]   r_count, w_countNext;
  logic              r_pending;
  logic [11:0]       r_avg;
  logic              r_avgValid;

  logic              w_accept;
  logic [7:0]        w_old;
  logic [SUM_W-1:0]  w_sumNext;
  logic [11:0]       w_avgNext;
  logic              w_emit;

  assign w_accept  = raw_valid & ~flush;
  assign w_old     = r_buf[r_wrPtr];
  assign w_sumNext = r_sum + SUM_W'(raw_data) - SUM_W'(w_old);
  // Upper bits of the shifted sum are always zero, so truncation is lossless.
  assign w_avgNext = 12'({r_sum, 4'b0000} >> LOG2_N);

`ifdef PWM_AVG_WARMUP_EN
  assign w_emit = r_pending & (r_state == FULL);
`else
  assign w_emit = r_pending;
`endif

  always_comb begin
    w_countNext = r_count;
    w_stateNext = r_state;
    if (flush) begin
      w_countNext = '0;
      w_stateNext = EMPTY;
    end else if (raw_valid) begin
      if (r_count != CNT_FULL) w_countNext = r_count + CNT_ONE;
      w_stateNext = (w_countNext == CNT_FULL) ? FULL : FILLING;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= EMPTY;
      r_count   <= '0;
      r_wrPtr   <= '0;
      r_sum     <= '0;
      r_pending <= 1'b0;
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_count   <= w_countNext;
      r_pending <= w_accept;
      if (flush) begin
        r_wrPtr <= '0;
        r_sum   <= '0;
        for (int i = 0; i < N; i++) r_buf[i] <= '0;
      end else if (raw_valid) begin
        r_buf[r_wrPtr] <= raw_data;
        r_wrPtr        <= r_wrPtr + PTR_ONE;
        r_sum          <= w_sumNext;
      end
    end
  end

  // Output stage sees the sum one edge after acceptance; flush never touches the held result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_avg      <= '0;
      r_avgValid <= 1'b0;
    end else begin
      r_avgValid <= w_emit;
      if (r_pending) r_avg <= w_avgNext;
    end
  end

  assign pwm_averaged = r_avg;
  assign avg_valid    = r_avgValid;
  assign window_full  = (r_state == FULL);

endmodule

// File: tb/tb_pwm_sample_averager.sv
// Table-driven bench with an output scoreboard for pwm_sample_averager (LOG2_N=4),
// plus a hand-driven LOG2_N=1 instance for the shift arithmetic.
module tb_pwm_sample_averager;

  typedef struct {
    logic        valid;
    logic        flush;
    logic [7:0]  data;
    logic [11:0] expAvg;
    logic        expFull;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rawValid = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  rawData = '0;
  logic [11:0] pwmAveraged;
  logic        avgValid;
  logic        windowFull;

  logic        rawValid1 = 1'b0;
  logic        flush1 = 1'b0;
  logic [7:0]  rawData1 = '0;
  logic [11:0] pwmAveraged1;
  logic        avgValid1;
  logic        windowFull1;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [11:0] sbQ [$];
  logic [11:0] sbExp;
  bit          ignoreMon = 1'b0;
  vec_t        vecs [$];

  pwm_sample_averager dut (
    .clk(clk), .reset(reset), .raw_valid(rawValid), .raw_data(rawData), .flush(flush),
    .pwm_averaged(pwmAveraged), .avg_valid(avgValid), .window_full(windowFull)
  );

  pwm_sample_averager #(.LOG2_N(1)) dut1 (
    .clk(clk), .reset(reset), .raw_valid(rawValid1), .raw_data(rawData1), .flush(flush1),
    .pwm_averaged(pwmAveraged1), .avg_valid(avgValid1), .window_full(windowFull1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic void addVec(input logic valid, input logic fl, input logic [7:0] data,
                                 input int expAvg, input logic expFull);
    vec_t v;
    v.valid   = valid;
    v.flush   = fl;
    v.data    = data;
    v.expAvg  = 12'(expAvg);
    v.expFull = expFull;
    vecs.push_back(v);
  endfunction

  // Called at a falling edge; drives one cycle and checks window_full one edge later.
  task automatic applyStimulus(input vec_t v, input string name);
    rawValid = v.valid;
    flush    = v.flush;
    rawData  = v.data;
    if (v.valid && !v.flush) begin
`ifdef PWM_AVG_WARMUP_EN
      if (v.expFull) sbQ.push_back(v.expAvg);
`else
      sbQ.push_back(v.expAvg);
`endif
    end
    @(negedge clk);
    checkOutput({name, " window_full"}, int'(windowFull), int'(v.expFull));
  endtask

  // Every avg_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && !ignoreMon && avgValid) begin
      if (sbQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected avg_valid: got pwm_averaged 0x%0h, expected no pulse", pwmAveraged);
      end else begin
        sbExp = sbQ.pop_front();
        checkOutput("avg scoreboard", int'(pwmAveraged), int'(sbExp));
      end
    end
  end

  initial begin
    vec_t v;
    int   waitCycles;

    for (int k = 1; k <= 16; k++) addVec(1'b1, 1'b0, 8'h80, 128 * k, k == 16);
    for (int j = 1; j <= 16; j++) addVec(1'b1, 1'b0, 8'hFF, 128 * (16 - j) + 255 * j, 1'b1);
    for (int j = 1; j <= 4; j++)  addVec(1'b1, 1'b0, 8'hFF, 4080, 1'b1);
    for (int j = 1; j <= 16; j++) addVec(1'b1, 1'b0, 8'h10, 255 * (16 - j) + 16 * j, 1'b1);
    for (int j = 1; j <= 16; j++) addVec(1'b1, 1'b0, 8'h20, 256 + 16 * j, 1'b1);
    addVec(1'b1, 1'b1, 8'h99, 0, 1'b0);
    addVec(1'b0, 1'b0, 8'h00, 0, 1'b0);
    addVec(1'b0, 1'b0, 8'h00, 0, 1'b0);

    repeat (2) @(negedge clk);
    checkOutput("reset pwm_averaged", int'(pwmAveraged), 0);
    checkOutput("reset avg_valid", int'(avgValid), 0);
    checkOutput("reset window_full", int'(windowFull), 0);
    checkOutput("reset n2 pwm_averaged", int'(pwmAveraged1), 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));
    checkOutput("flush holds pwm_averaged", int'(pwmAveraged), 12'h200);

    v = '{valid: 1'b1, flush: 1'b0, data: 8'h40, expAvg: 12'h040, expFull: 1'b0};
    applyStimulus(v, "post-flush 0x40");
    v = '{valid: 1'b0, flush: 1'b0, data: 8'h00, expAvg: 12'h000, expFull: 1'b0};
    applyStimulus(v, "idle a");
    applyStimulus(v, "idle b");

    ignoreMon = 1'b1;
    rawValid  = 1'b1;
    rawData   = 8'h55;
    repeat (3) @(negedge clk);
    reset    = 1'b1;
    rawValid = 1'b0;
    sbQ.delete();
    @(negedge clk);
    checkOutput("mid-burst reset pwm_averaged", int'(pwmAveraged), 0);
    checkOutput("mid-burst reset window_full", int'(windowFull), 0);
    reset     = 1'b0;
    ignoreMon = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput($sformatf("post-reset avg_valid c%0d", c), int'(avgValid), 0);
      checkOutput($sformatf("post-reset pwm_averaged c%0d", c), int'(pwmAveraged), 0);
    end
    v = '{valid: 1'b1, flush: 1'b0, data: 8'h33, expAvg: 12'h033, expFull: 1'b0};
    applyStimulus(v, "post-reset 0x33");
    checkOutput("post-reset output not yet updated", int'(pwmAveraged), 0);
    v = '{valid: 1'b0, flush: 1'b0, data: 8'h00, expAvg: 12'h000, expFull: 1'b0};
    applyStimulus(v, "idle c");
    applyStimulus(v, "idle d");

    rawValid1 = 1'b1;
    rawData1  = 8'd1;
    @(negedge clk);
    rawData1 = 8'd2;
    @(negedge clk);
`ifdef PWM_AVG_WARMUP_EN
    checkOutput("n2 first sample no pulse", int'(avgValid1), 0);
`else
    checkOutput("n2 first sample pulse", int'(avgValid1), 1);
    checkOutput("n2 first sample avg", int'(pwmAveraged1), 8);
`endif
    rawData1 = 8'd0;
    @(negedge clk);
    checkOutput("n2 avg of 1,2 valid", int'(avgValid1), 1);
    checkOutput("n2 avg of 1,2", int'(pwmAveraged1), 24);
    rawData1 = 8'd1;
    @(negedge clk);
    rawData1 = 8'd0;
    @(negedge clk);
    checkOutput("n2 alternating avg", int'(pwmAveraged1), 8);
    rawData1 = 8'd1;
    @(negedge clk);
    checkOutput("n2 alternating avg steady", int'(pwmAveraged1), 8);
    checkOutput("n2 window_full", int'(windowFull1), 1);
    rawValid1 = 1'b0;

    waitCycles = 0;
    while (sbQ.size() != 0 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("scoreboard drained", sbQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
